// File: rtl/inert_pkg.sv
// Shared types and constants for the inertial sensor SPI front end.
// Holds the sequencer and SPI engine state encodings plus the sensor register map.
package inert_pkg;

    typedef enum logic [3:0] {
        PWR_WAIT,
        INIT1,
        INIT2,
        INIT3,
        INIT4,
        WAIT_INT,
        RD_PL,
        RD_PH,
        RD_AL,
        RD_AH,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        SPI_IDLE,
        SPI_SHIFT,
        SPI_BACK
    } spi_state_t;

    localparam logic [15:0] CFG_INT   = 16'h0D02;
    localparam logic [15:0] CFG_ACCEL = 16'h1053;
    localparam logic [15:0] CFG_GYRO  = 16'h1150;
    localparam logic [15:0] CFG_ROUND = 16'h1460;

    localparam logic [7:0] PITCH_L = 8'h22;
    localparam logic [7:0] PITCH_H = 8'h23;
    localparam logic [7:0] AZ_L    = 8'h2C;
    localparam logic [7:0] AZ_H    = 8'h2D;

    // Read frames carry the read flag in bit 15 and a don't-care low byte.
    function automatic logic [15:0] rd_cmd(input logic [7:0] addr);
        return {1'b1, addr[6:0], 8'h00};
    endfunction

endpackage

// File: rtl/spi_mnrch.sv
// 16-bit mode-3 SPI master: SCLK divider, bit counter and a shared tx/rx shift register.
// One transaction per wrt strobe; done pulses for one clock when SS_n rises.
module spi_mnrch
    import inert_pkg::*;
#(
    parameter int unsigned SCLK_DIV_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wrt,
    input  logic [15:0] wt_data,
    output logic        done,
    output logic [15:0] rd_data,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    // Divider starts at half scale so SCLK (its MSB) stays high through the front porch.
    localparam logic [SCLK_DIV_W-1:0] DIV_HALF = {1'b1, {(SCLK_DIV_W-1){1'b0}}};
    localparam logic [SCLK_DIV_W-1:0] DIV_RISE = {1'b0, {(SCLK_DIV_W-1){1'b1}}};

    spi_state_t            state_q, state_d;
    logic [SCLK_DIV_W-1:0] div_q, div_d;
    logic [3:0]            bit_q, bit_d;
    logic [15:0]           shft_q, shft_d;
    logic                  ss_n_q, ss_n_d;
    logic                  mosi_q, mosi_d;
    logic                  done_q, done_d;
    logic                  sclk_fall, sclk_rise;

    assign sclk_fall = (state_q == SPI_SHIFT) && (div_q == '1);
    assign sclk_rise = (state_q == SPI_SHIFT) && (div_q == DIV_RISE);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shft_d  = shft_q;
        ss_n_d  = ss_n_q;
        mosi_d  = mosi_q;
        done_d  = 1'b0;
        unique case (state_q)
            SPI_IDLE: begin
                div_d = DIV_HALF;
                if (wrt) begin
                    ss_n_d  = 1'b0;
                    shft_d  = wt_data;
                    bit_d   = '0;
                    state_d = SPI_SHIFT;
                end
            end
            SPI_SHIFT: begin
                div_d = div_q + 1'b1;
                if (sclk_fall) begin
                    mosi_d = shft_q[15];
                    shft_d = {shft_q[14:0], 1'b0};
                end
                if (sclk_rise) begin
                    shft_d[0] = MISO;
                    bit_d     = bit_q + 4'd1;
                    if (bit_q == 4'd15) begin
                        state_d = SPI_BACK;
                    end
                end
            end
            SPI_BACK: begin
                ss_n_d  = 1'b1;
                done_d  = 1'b1;
                state_d = SPI_IDLE;
            end
            default: state_d = SPI_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SPI_IDLE;
            div_q   <= DIV_HALF;
            bit_q   <= '0;
            shft_q  <= '0;
            ss_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shft_q  <= shft_d;
            ss_n_q  <= ss_n_d;
            mosi_q  <= mosi_d;
            done_q  <= done_d;
        end
    end

    assign SS_n    = ss_n_q;
    assign SCLK    = div_q[SCLK_DIV_W-1];
    assign MOSI    = mosi_q;
    assign done    = done_q;
    assign rd_data = shft_q;

endmodule

// File: rtl/inert_intf.sv
// Inertial sensor front end: power-up wait, sensor configuration, then one pitch-rate/AZ
// read burst per data-ready interrupt, presented with a one-clock vld strobe.
module inert_intf
    import inert_pkg::*;
#(
    parameter int unsigned INIT_WAIT_W = 16,
    parameter int unsigned SCLK_DIV_W  = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        INT,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic        vld,
    output logic [15:0] ptch_rt,
    output logic [15:0] AZ
);

    state_t                 state_q, state_d;
    logic [INIT_WAIT_W-1:0] wait_q, wait_d;
    logic                   int_ff1_q, int_ff2_q;
    logic [7:0]             pl_q, pl_d, ph_q, ph_d, al_q, al_d, ah_q, ah_d;
    logic [15:0]            ptch_q, ptch_d, az_q, az_d;
    logic                   vld_q, vld_d;
    logic                   wrt, done;
    logic [15:0]            wt_data, rd_data;
    logic                   unused_rd_hi;

    // Only the low byte of each read frame carries register data.
    assign unused_rd_hi = ^rd_data[15:8];

    spi_mnrch #(
        .SCLK_DIV_W(SCLK_DIV_W)
    ) u_spi (
        .clk    (clk),
        .rst    (rst),
        .wrt    (wrt),
        .wt_data(wt_data),
        .done   (done),
        .rd_data(rd_data),
        .SS_n   (SS_n),
        .SCLK   (SCLK),
        .MOSI   (MOSI),
        .MISO   (MISO)
    );

    // Each state names the transaction in flight; wrt fires on the way in, done moves on.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        pl_d    = pl_q;
        ph_d    = ph_q;
        al_d    = al_q;
        ah_d    = ah_q;
        ptch_d  = ptch_q;
        az_d    = az_q;
        vld_d   = 1'b0;
        wrt     = 1'b0;
        wt_data = '0;
        unique case (state_q)
            PWR_WAIT: begin
                wait_d = wait_q + 1'b1;
                if (&wait_q) begin
                    wrt     = 1'b1;
                    wt_data = CFG_INT;
                    state_d = INIT1;
                end
            end
            INIT1: if (done) begin
                wrt     = 1'b1;
                wt_data = CFG_ACCEL;
                state_d = INIT2;
            end
            INIT2: if (done) begin
                wrt     = 1'b1;
                wt_data = CFG_GYRO;
                state_d = INIT3;
            end
            INIT3: if (done) begin
                wrt     = 1'b1;
                wt_data = CFG_ROUND;
                state_d = INIT4;
            end
            INIT4: if (done) state_d = WAIT_INT;
            WAIT_INT: if (int_ff2_q) begin
                wrt     = 1'b1;
                wt_data = rd_cmd(PITCH_L);
                state_d = RD_PL;
            end
            RD_PL: if (done) begin
                pl_d    = rd_data[7:0];
                wrt     = 1'b1;
                wt_data = rd_cmd(PITCH_H);
                state_d = RD_PH;
            end
            RD_PH: if (done) begin
                ph_d    = rd_data[7:0];
                wrt     = 1'b1;
                wt_data = rd_cmd(AZ_L);
                state_d = RD_AL;
            end
            RD_AL: if (done) begin
                al_d    = rd_data[7:0];
                wrt     = 1'b1;
                wt_data = rd_cmd(AZ_H);
                state_d = RD_AH;
            end
            RD_AH: if (done) begin
                ah_d    = rd_data[7:0];
                state_d = DONE;
            end
            DONE: begin
                ptch_d  = {ph_q, pl_q};
                az_d    = {ah_q, al_q};
                vld_d   = 1'b1;
                state_d = WAIT_INT;
            end
            default: state_d = PWR_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= PWR_WAIT;
            wait_q    <= '0;
            int_ff1_q <= 1'b0;
            int_ff2_q <= 1'b0;
            pl_q      <= '0;
            ph_q      <= '0;
            al_q      <= '0;
            ah_q      <= '0;
            ptch_q    <= '0;
            az_q      <= '0;
            vld_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            int_ff1_q <= INT;
            int_ff2_q <= int_ff1_q;
            pl_q      <= pl_d;
            ph_q      <= ph_d;
            al_q      <= al_d;
            ah_q      <= ah_d;
            ptch_q    <= ptch_d;
            az_q      <= az_d;
            vld_q     <= vld_d;
        end
    end

    assign vld     = vld_q;
    assign ptch_rt = ptch_q;
    assign AZ      = az_q;

endmodule

// File: tb/tb_inert_intf.sv
// Self-checking bench for inert_intf: behavioural SPI sensor slave with a register map,
// transaction log, SCLK timing monitor and vld/output capture.
module tb_inert_intf;

    // Shortened power-up wait keeps two full initialisations within a small cycle budget.
    localparam int unsigned INIT_WAIT_W = 12;
    localparam int unsigned SCLK_DIV_W  = 5;
    localparam int          CLK_T       = 10;
    localparam int          PWR_CYCLES  = (1 << INIT_WAIT_W) - 1;
    localparam int          SCLK_T      = CLK_T * (1 << SCLK_DIV_W);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        INT = 1'b0;
    logic        MISO = 1'b0;
    logic        SS_n, SCLK, MOSI, vld;
    logic [15:0] ptch_rt, AZ;

    inert_intf #(
        .INIT_WAIT_W(INIT_WAIT_W),
        .SCLK_DIV_W (SCLK_DIV_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .INT    (INT),
        .MISO   (MISO),
        .SS_n   (SS_n),
        .SCLK   (SCLK),
        .MOSI   (MOSI),
        .vld    (vld),
        .ptch_rt(ptch_rt),
        .AZ     (AZ)
    );

    always #(CLK_T / 2) clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] cfg_exp [0:3] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
    logic [15:0] rd_exp  [0:3] = '{16'hA200, 16'hA300, 16'hAC00, 16'hAD00};

    // Sensor model: register map, full-duplex frame capture, timing checks.
    logic [7:0]  regs [0:127];
    logic [15:0] cmd_q [$];
    int          nfall_q [$];
    logic [15:0] rx;
    logic [7:0]  tx_byte;
    int          nrise, nfall;
    time         t_ss, t_fall;
    int          period_bad = 0;
    int          porch_bad = 0;

    initial forever begin
        @(negedge SS_n);
        rx    = '0;
        nrise = 0;
        nfall = 0;
        t_ss  = $time;
    end

    initial forever begin
        @(negedge SCLK);
        if (SS_n === 1'b0) begin
            nfall++;
            if (nfall == 1) begin
                if ($time - t_ss != SCLK_T / 2) porch_bad++;
            end else if ($time - t_fall != SCLK_T) begin
                period_bad++;
            end
            t_fall = $time;
            // Address phase: the sensor drives junk; data phase: the addressed register.
            if (nfall <= 8) MISO = 1'($urandom_range(0, 1));
            else if (nfall <= 16) MISO = tx_byte[16 - nfall];
            else MISO = 1'b0;
        end
    end

    initial forever begin
        @(posedge SCLK);
        if (SS_n === 1'b0) begin
            rx = {rx[14:0], MOSI};
            nrise++;
            if (nrise == 8) tx_byte = regs[rx[6:0]];
        end
    end

    initial forever begin
        @(posedge SS_n);
        cmd_q.push_back(rx);
        nfall_q.push_back(nfall);
    end

    // Output capture: every strobe, plus any output change outside a strobe or reset.
    int          vld_cnt = 0;
    logic [15:0] vp_q [$];
    logic [15:0] va_q [$];
    int          unstable = 0;
    logic [15:0] last_p = '0;
    logic [15:0] last_a = '0;

    initial forever begin
        @(negedge clk);
        if (vld === 1'b1) begin
            vld_cnt++;
            vp_q.push_back(ptch_rt);
            va_q.push_back(AZ);
            last_p = ptch_rt;
            last_a = AZ;
        end else if (rst) begin
            last_p = ptch_rt;
            last_a = AZ;
        end else if (ptch_rt !== last_p || AZ !== last_a) begin
            unstable++;
        end
    end

    initial begin
        #(CLK_T * 60000);
        $display("FAIL watchdog: simulation time limit reached, observed hang, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        cmd_q.delete();
        nfall_q.delete();
    endtask

    task automatic wait_pwr(input string tag, input bit poke_int);
        int cnt = 0;
        while (SS_n === 1'b1 && cnt < PWR_CYCLES + 100) begin
            tick(1);
            cnt++;
            if (poke_int) INT = (cnt >= 100 && cnt < 110) || (cnt >= PWR_CYCLES - 20 && cnt < PWR_CYCLES - 12);
        end
        INT = 1'b0;
        check({tag, "_pwr_quiet"}, 32'(cnt > PWR_CYCLES && cnt <= PWR_CYCLES + 2), 1);
    endtask

    task automatic wait_txns(input string tag, input int n);
        int cnt = 0;
        while (cmd_q.size() < n && cnt < n * 700 + 200) begin
            tick(1);
            cnt++;
        end
        check({tag, "_txn_timeout"}, 32'(cmd_q.size() >= n), 1);
    endtask

    task automatic check_cfg(input string tag);
        logic [15:0] c;
        int          f;
        check({tag, "_ntx"}, cmd_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            c = 'x;
            f = -1;
            if (i < cmd_q.size()) begin
                c = cmd_q[i];
                f = nfall_q[i];
            end
            check($sformatf("%s_cmd%0d", tag, i), c, cfg_exp[i]);
            check($sformatf("%s_falls%0d", tag, i), f, 16);
        end
        check({tag, "_sclk_period"}, period_bad, 0);
        check({tag, "_front_porch"}, porch_bad, 0);
    endtask

    task automatic check_reads(input string tag, input int first);
        logic [15:0] c;
        for (int i = 0; i < 4; i++) begin
            c = 'x;
            if (first + i < cmd_q.size()) c = cmd_q[first + i];
            check($sformatf("%s_rdcmd%0d", tag, i), c, rd_exp[i]);
        end
    endtask

    task automatic check_pair(input string tag, input int idx, input logic [15:0] ep,
                              input logic [15:0] ea);
        logic [15:0] p, a;
        p = 'x;
        a = 'x;
        if (idx >= 0 && idx < vp_q.size()) begin
            p = vp_q[idx];
            a = va_q[idx];
        end
        check({tag, "_ptch_rt"}, p, ep);
        check({tag, "_AZ"}, a, ea);
    endtask

    task automatic wait_vld(input string tag, input int target);
        int cnt = 0;
        while (vld_cnt < target && cnt < 4000) begin
            tick(1);
            cnt++;
        end
        check({tag, "_vld_timeout"}, 32'(vld_cnt >= target), 1);
    endtask

    task automatic read_cycle(input string tag);
        int          base;
        logic [15:0] ep, ea;
        base = vld_cnt;
        ep   = {regs[8'h23], regs[8'h22]};
        ea   = {regs[8'h2D], regs[8'h2C]};
        clear_log();
        INT = 1'b1;
        tick(3);
        INT = 1'b0;
        wait_vld(tag, base + 1);
        tick(300);
        check({tag, "_nvld"}, vld_cnt - base, 1);
        check({tag, "_ntx"}, cmd_q.size(), 4);
        check_reads(tag, 0);
        check_pair(tag, vp_q.size() - 1, ep, ea);
    endtask

    initial begin
        int          base;
        int          cnt;
        logic [15:0] ep1, ea1, ep2, ea2;

        for (int i = 0; i < 128; i++) regs[i] = 8'($urandom);

        // Reset state
        tick(2);
        check("rst_SS_n", SS_n, 1);
        check("rst_SCLK", SCLK, 1);
        check("rst_MOSI", MOSI, 0);
        check("rst_vld", vld, 0);
        check("rst_ptch_rt", ptch_rt, 0);
        check("rst_AZ", AZ, 0);
        clear_log();
        rst = 1'b0;

        // Power-up wait and configuration, with INT activity that must be ignored
        wait_pwr("init", 1'b1);
        tick(700);
        INT = 1'b1;
        tick(5);
        INT = 1'b0;
        wait_txns("init", 4);
        tick(2000);
        check_cfg("init");
        check("init_no_vld", vld_cnt, 0);

        // Directed read
        regs[8'h22] = 8'h34;
        regs[8'h23] = 8'h12;
        regs[8'h2C] = 8'h9C;
        regs[8'h2D] = 8'hFF;
        read_cycle("rd_dir");
        check("rd_dir_ptch_rt_port", ptch_rt, 16'h1234);
        check("rd_dir_AZ_port", AZ, 16'hFF9C);

        // INT held low: no traffic
        clear_log();
        base = vld_cnt;
        tick(2000);
        check("idle_ntx", cmd_q.size(), 0);
        check("idle_nvld", vld_cnt - base, 0);

        // Randomised reads against the register map
        for (int r = 0; r < 3; r++) begin
            regs[8'h22] = 8'($urandom);
            regs[8'h23] = 8'($urandom);
            regs[8'h2C] = 8'($urandom);
            regs[8'h2D] = 8'($urandom);
            read_cycle($sformatf("rd_rand%0d", r));
        end

        // Back-to-back reads with INT held high
        regs[8'h22] = 8'($urandom);
        regs[8'h23] = 8'($urandom);
        regs[8'h2C] = 8'($urandom);
        regs[8'h2D] = 8'($urandom);
        ep1 = {regs[8'h23], regs[8'h22]};
        ea1 = {regs[8'h2D], regs[8'h2C]};
        clear_log();
        base = vld_cnt;
        INT = 1'b1;
        wait_vld("b2b_first", base + 1);
        regs[8'h22] = regs[8'h22] ^ 8'h5A;
        regs[8'h23] = regs[8'h23] ^ 8'hC3;
        regs[8'h2C] = regs[8'h2C] ^ 8'h0F;
        regs[8'h2D] = regs[8'h2D] ^ 8'hF1;
        ep2 = {regs[8'h23], regs[8'h22]};
        ea2 = {regs[8'h2D], regs[8'h2C]};
        tick(100);
        INT = 1'b0;
        wait_vld("b2b_second", base + 2);
        tick(300);
        check("b2b_nvld", vld_cnt - base, 2);
        check("b2b_ntx", cmd_q.size(), 8);
        check_reads("b2b_a", 0);
        check_reads("b2b_b", 4);
        check_pair("b2b_a", vp_q.size() - 2, ep1, ea1);
        check_pair("b2b_b", vp_q.size() - 1, ep2, ea2);
        check("outputs_stable", unstable, 0);

        // Reset during the RD_AH transaction
        clear_log();
        base = vld_cnt;
        INT = 1'b1;
        tick(3);
        INT = 1'b0;
        cnt = 0;
        while (cmd_q.size() < 3 && cnt < 3000) begin
            tick(1);
            cnt++;
        end
        cnt = 0;
        while (SS_n !== 1'b0 && cnt < 50) begin
            tick(1);
            cnt++;
        end
        tick(100);
        check("mid_rd_ss_low", SS_n, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_SS_n", SS_n, 1);
        check("mid_rst_SCLK", SCLK, 1);
        tick(2);
        rst = 1'b0;
        clear_log();
        period_bad = 0;
        porch_bad  = 0;
        wait_pwr("rerun", 1'b0);
        wait_txns("rerun", 4);
        tick(500);
        check_cfg("rerun");
        check("rerun_no_vld", vld_cnt - base, 0);
        check("rerun_ptch_rt", ptch_rt, 0);
        check("rerun_AZ", AZ, 0);
        check("final_stable", unstable, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
